// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the CPU data-side SRAM-like bus: size codes, response
// entry layout and the stall LFSR constants used by the bus responders.
`timescale 1ns/1ps
package cpu_bus_pkg;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  typedef struct packed {
    logic        wr;
    logic [31:0] data;
  } resp_entry_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Galois form of x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/resp_fifo.sv
// In-order response queue for data_sram_responder; pointers wrap modulo DEPTH
// so non-power-of-two depths work.
`timescale 1ns/1ps
module resp_fifo
  import cpu_bus_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  resp_entry_t push_data,
  input  logic        pop,
  output resp_entry_t head,
  output logic [2:0]  count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  resp_entry_t   mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wrap_inc(wr_ptr);
      if (pop)  rd_ptr <= wrap_inc(rd_ptr);
      count <= count + 3'(push) - 3'(pop);
    end
  end

  // NOTE: entry storage is deliberately left out of reset; count alone says
  // which slots are live, and an unreset array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/data_sram_responder.sv
// Responder end of the CPU data-side SRAM-like bus backed by a word array.
// Define RAND_STALL_EN to add LFSR-driven addr_ok stalls and response jitter.
`timescale 1ns/1ps
module data_sram_responder
  import cpu_bus_pkg::*;
#(
  parameter int AW      = 10,
  parameter int LATENCY = 2,
  parameter int OUTST   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [31:0] data_sram_addr,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata
);

  localparam int TW = 5;

  logic [31:0]   mem [2**AW];
  logic [AW-1:0] idx;
  resp_entry_t   push_data;
  resp_entry_t   head;
  logic [2:0]    count;
  logic [TW-1:0] timer;
  logic [TW-1:0] load_val;
  logic          accept;
  logic          pop;
  logic          room;
  logic          load;

  assign idx  = data_sram_addr[AW+1:2];
  assign room = count < 3'(OUTST);

`ifdef RAND_STALL_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk) begin
    if (reset) lfsr <= LFSR_SEED;
    else       lfsr <= lfsr_next(lfsr);
  end

  assign data_sram_addr_ok = data_sram_req && room && !lfsr[0];
  assign load_val          = TW'(LATENCY - 1) + TW'(lfsr[3:2]);
`else
  assign data_sram_addr_ok = data_sram_req && room;
  assign load_val          = TW'(LATENCY - 1);
`endif

  assign accept            = data_sram_addr_ok;
  assign data_sram_data_ok = (count != 3'd0) && (timer == '0);
  assign pop               = data_sram_data_ok;
  assign data_sram_rdata   = data_sram_data_ok ? head.data : 32'd0;

  // NOTE: the array write is non-blocking, so the read capture below always
  // sees the word as it stood before this edge.
  always_ff @(posedge clk) begin
    if (accept && data_sram_wr && !reset) begin
      for (int b = 0; b < 4; b++) begin
        if (data_sram_wstrb[b]) mem[idx][8*b +: 8] <= data_sram_wdata[8*b +: 8];
      end
    end
  end

  always_comb begin
    push_data.wr   = data_sram_wr;
    push_data.data = data_sram_wr ? 32'd0 : mem[idx];
  end

  // A new head appears on push into an empty queue, or on a pop that leaves
  // a successor (including one pushed in the same cycle).
  assign load = accept ? ((count == 3'd0) || pop) : (pop && (count > 3'd1));

  always_ff @(posedge clk) begin
    if (reset)              timer <= '0;
    else if (load)          timer <= load_val;
    else if (timer != '0)   timer <= timer - 1'b1;
  end

  resp_fifo #(.DEPTH(OUTST)) u_resp_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (accept),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  logic unused_bits;
  assign unused_bits = ^{data_sram_size, data_sram_addr[31:AW+2], data_sram_addr[1:0], head.wr};

endmodule

// File: tb/tb_data_sram_responder.sv
// Scoreboard bench for data_sram_responder: directed bus scenarios followed by
// randomized traffic against a word-array reference model.
`timescale 1ns/1ps
module tb_data_sram_responder;

  localparam int AW      = 10;
  localparam int LATENCY = 2;
  localparam int OUTST   = 2;
  localparam int NPOOL   = 16;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        req   = 1'b0;
  logic        wr    = 1'b0;
  logic [1:0]  size  = 2'd2;
  logic [31:0] addr  = 32'd0;
  logic [3:0]  wstrb = 4'd0;
  logic [31:0] wdata = 32'd0;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  data_sram_responder #(.AW(AW), .LATENCY(LATENCY), .OUTST(OUTST)) dut (
    .clk               (clk),
    .reset             (reset),
    .data_sram_req     (req),
    .data_sram_wr      (wr),
    .data_sram_size    (size),
    .data_sram_addr    (addr),
    .data_sram_wstrb   (wstrb),
    .data_sram_wdata   (wdata),
    .data_sram_addr_ok (addr_ok),
    .data_sram_data_ok (data_ok),
    .data_sram_rdata   (rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    logic [31:0] data;
    int          exp_cyc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mdl [2**AW];
  int          pool [NPOOL];
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          n_out = 0;
  exp_t        mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Expected data_ok cycle offset; response jitter makes it meaningless with stalls.
  function automatic int lat(input int x);
`ifdef RAND_STALL_EN
    return -1;
`else
    return x;
`endif
  endfunction

  // Monitor: pops the scoreboard on every response, independent of the driver.
  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
      n_out = 0;
    end else begin
      if (addr_ok) check("addr_ok_while_full", 32'(n_out < OUTST), 32'd1);
      if (data_ok) begin
        if (sb.size() == 0) begin
          check("unexpected_data_ok", 32'd1, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          check(mon_e.wr ? "write_resp_rdata" : "read_resp_rdata", rdata, mon_e.data);
          if (mon_e.exp_cyc >= 0) check("data_ok_cycle", cyc, mon_e.exp_cyc);
        end
      end else begin
        check("idle_rdata", rdata, 32'd0);
      end
      n_out = n_out + int'(addr_ok) - int'(data_ok);
    end
  end

  // Presents one request until accepted, then records its expected response.
  task automatic issue(input bit w, input logic [31:0] a, input logic [3:0] s,
                       input logic [31:0] d, input int l, input bit post_rst,
                       output int acc);
    int   wi;
    bit   got;
    exp_t e;
    got = 1'b0;
    acc = -1;
    wi  = int'(a[AW+1:2]);
    req = 1'b1; wr = w; addr = a; wstrb = s; wdata = d;
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge clk);
      if (post_rst && i == 0) begin
        check("post_reset_data_ok", 32'(data_ok), 32'd0);
`ifndef RAND_STALL_EN
        check("post_reset_addr_ok", 32'(addr_ok), 32'd1);
`endif
      end
      if (addr_ok) begin
        got       = 1'b1;
        acc       = cyc;
        e.wr      = w;
        e.exp_cyc = (l < 0) ? -1 : cyc + l;
        if (w) begin
          for (int b = 0; b < 4; b++) if (s[b]) mdl[wi][8*b +: 8] = d[8*b +: 8];
          e.data = 32'd0;
        end else begin
          e.data = mdl[wi];
        end
        sb.push_back(e);
      end
    end
    if (!got) begin
      req = 1'b0;
      check("accept_timeout", 32'd0, 32'd1);
    end
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  task automatic wait_idle();
    int i;
    i = 0;
    while (sb.size() != 0 && i < 200) begin
      @(negedge clk); #1;
      i++;
    end
    if (sb.size() != 0) check("drain_timeout", 32'(sb.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a1, a2, a3, dummy;
    logic [31:0] ra;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_data_ok", 32'(data_ok), 32'd0);
    check("reset_rdata", rdata, 32'd0);
    check("reset_addr_ok_no_req", 32'(addr_ok), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // single write then read
    issue(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, lat(LATENCY), 1'b0, dummy);
    wait_idle();
    issue(1'b0, 32'h10, 4'h0, 32'h0, lat(LATENCY), 1'b0, dummy);
    wait_idle();

    // byte strobe merge
    issue(1'b1, 32'h10, 4'b0100, 32'h00AA0000, lat(LATENCY), 1'b0, dummy);
    wait_idle();
    issue(1'b0, 32'h10, 4'h0, 32'h0, lat(LATENCY), 1'b0, dummy);
    wait_idle();

    // back-to-back reads against a two-deep queue
    issue(1'b0, 32'h10, 4'h0, 32'h0, lat(2), 1'b0, a1);
    issue(1'b0, 32'h10, 4'h0, 32'h0, lat(3), 1'b0, a2);
    issue(1'b0, 32'h10, 4'h0, 32'h0, lat(3), 1'b0, a3);
`ifndef RAND_STALL_EN
    check("b2b_second_accept", a2, a1 + 1);
    check("b2b_third_accept", a3, a1 + 3);
`endif
    wait_idle();

    // read-after-write ordering
    issue(1'b1, 32'h20, 4'hF, 32'h12345678, lat(2), 1'b0, dummy);
    issue(1'b0, 32'h20, 4'h0, 32'h0, lat(3), 1'b0, dummy);
    wait_idle();

    // reset with two responses queued; committed write survives
    issue(1'b1, 32'h30, 4'hF, 32'hCAFEF00D, -1, 1'b0, dummy);
    issue(1'b0, 32'h10, 4'h0, 32'h0, -1, 1'b0, dummy);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    issue(1'b0, 32'h30, 4'h0, 32'h0, lat(LATENCY), 1'b1, dummy);
    wait_idle();

    // randomized traffic over an aliased address pool
    for (int k = 0; k < NPOOL; k++) begin
      pool[k] = 4 + 5 * k;
      ra = $urandom;
      ra[AW+1:2] = AW'(pool[k]);
      issue(1'b1, ra, 4'hF, $urandom, -1, 1'b0, dummy);
    end
    for (int n = 0; n < 1000; n++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      ra = $urandom;
      ra[AW+1:2] = AW'(pool[$urandom_range(0, NPOOL - 1)]);
      if ($urandom_range(0, 1) == 1)
        issue(1'b1, ra, 4'($urandom), $urandom, -1, 1'b0, dummy);
      else
        issue(1'b0, ra, 4'h0, 32'h0, -1, 1'b0, dummy);
    end
    wait_idle();
    check("final_scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
